// File: rtl/screen_pkg.sv
// Shared constants for the 512x256 monochrome screen scan-out path.
// SCREEN_SCANOUT_LINE_DOUBLE_EN selects line doubling (512 visible lines, each row shown twice).
package screen_pkg;

    localparam int unsigned SCREEN_WIDTH  = 512;
    localparam int unsigned SCREEN_HEIGHT = 256;
    localparam int unsigned WORDS_PER_ROW = 32;
    localparam int unsigned FB_WORDS      = 8192;
    localparam int unsigned FB_ADDR_W     = 13;
    localparam int unsigned WORD_W        = 16;

    localparam int unsigned H_FP_DEF   = 16;
    localparam int unsigned H_SYNC_DEF = 96;
    localparam int unsigned H_BP_DEF   = 48;
    localparam int unsigned V_FP_DEF   = 10;
    localparam int unsigned V_SYNC_DEF = 2;
    localparam int unsigned V_BP_DEF   = 33;

    // Wide enough for any sensible porch setting on either axis.
    localparam int unsigned CNT_W = 11;

`ifdef SCREEN_SCANOUT_LINE_DOUBLE_EN
    localparam int unsigned V_ACT = 2 * SCREEN_HEIGHT;
`else
    localparam int unsigned V_ACT = SCREEN_HEIGHT;
`endif

    function automatic int unsigned line_total(input int unsigned act, input int unsigned fp,
                                               input int unsigned sync, input int unsigned bp);
        return act + fp + sync + bp;
    endfunction

endpackage

// File: rtl/scanout_timing.sv
// Raster counters, active-area flag and raw (undelayed) sync generation.
// V_ACT depends on SCREEN_SCANOUT_LINE_DOUBLE_EN through screen_pkg.
module scanout_timing
    import screen_pkg::*;
#(
    parameter int unsigned H_FP   = H_FP_DEF,
    parameter int unsigned H_SYNC = H_SYNC_DEF,
    parameter int unsigned H_BP   = H_BP_DEF,
    parameter int unsigned V_FP   = V_FP_DEF,
    parameter int unsigned V_SYNC = V_SYNC_DEF,
    parameter int unsigned V_BP   = V_BP_DEF
) (
    input  logic             clk,
    input  logic             reset,
    output logic [CNT_W-1:0] hc,
    output logic [CNT_W-1:0] vc,
    output logic             active,
    output logic             hsync_raw,
    output logic             vsync_raw,
    output logic             first_pixel
);

    localparam int unsigned H_TOTAL  = line_total(SCREEN_WIDTH, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL  = line_total(V_ACT, V_FP, V_SYNC, V_BP);
    localparam int unsigned HS_START = SCREEN_WIDTH + H_FP;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_ACT + V_FP;
    localparam int unsigned VS_END   = VS_START + V_SYNC;

    logic [CNT_W-1:0] hc_q, hc_d;
    logic [CNT_W-1:0] vc_q, vc_d;

    always_comb begin
        hc_d = hc_q + 1'b1;
        vc_d = vc_q;
        if (hc_q == CNT_W'(H_TOTAL - 1)) begin
            hc_d = '0;
            vc_d = (vc_q == CNT_W'(V_TOTAL - 1)) ? '0 : vc_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            hc_q <= '0;
            vc_q <= '0;
        end else begin
            hc_q <= hc_d;
            vc_q <= vc_d;
        end
    end

    assign hc          = hc_q;
    assign vc          = vc_q;
    assign active      = (hc_q < CNT_W'(SCREEN_WIDTH)) && (vc_q < CNT_W'(V_ACT));
    assign hsync_raw   = !((hc_q >= CNT_W'(HS_START)) && (hc_q < CNT_W'(HS_END)));
    assign vsync_raw   = !((vc_q >= CNT_W'(VS_START)) && (vc_q < CNT_W'(VS_END)));
    assign first_pixel = (hc_q == '0) && (vc_q == '0);

endmodule

// File: rtl/screen_scanout.sv
// Framebuffer scan-out: word fetch, pixel shift register and 2-cycle output alignment.
// SCREEN_SCANOUT_LINE_DOUBLE_EN fetches each framebuffer row on two consecutive lines.
module screen_scanout
    import screen_pkg::*;
#(
    parameter int unsigned H_FP   = H_FP_DEF,
    parameter int unsigned H_SYNC = H_SYNC_DEF,
    parameter int unsigned H_BP   = H_BP_DEF,
    parameter int unsigned V_FP   = V_FP_DEF,
    parameter int unsigned V_SYNC = V_SYNC_DEF,
    parameter int unsigned V_BP   = V_BP_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic                 fb_rd,
    output logic [FB_ADDR_W-1:0] fb_addr,
    input  logic [WORD_W-1:0]    fb_data,
    output logic                 video_color,
    output logic                 video_hsync,
    output logic                 video_vsync,
    output logic                 video_de,
    output logic                 frame_start
);

    logic [CNT_W-1:0] hc, vc;
    logic             active, hsync_raw, vsync_raw, first_pixel;

    scanout_timing #(
        .H_FP   (H_FP),
        .H_SYNC (H_SYNC),
        .H_BP   (H_BP),
        .V_FP   (V_FP),
        .V_SYNC (V_SYNC),
        .V_BP   (V_BP)
    ) u_timing (
        .clk         (clk),
        .reset       (reset),
        .hc          (hc),
        .vc          (vc),
        .active      (active),
        .hsync_raw   (hsync_raw),
        .vsync_raw   (vsync_raw),
        .first_pixel (first_pixel)
    );

    logic [7:0] row;
`ifdef SCREEN_SCANOUT_LINE_DOUBLE_EN
    assign row = vc[8:1];
`else
    assign row = vc[7:0];
`endif

    logic unused_cnt;
    assign unused_cnt = ^{hc, vc};

    // Gated by reset so no read is issued while reset is held.
    logic fetch;
    assign fetch   = reset && active && (hc[3:0] == 4'd0);
    assign fb_rd   = fetch;
    assign fb_addr = fetch ? {row, hc[8:4]} : '0;

    // Stage 1: counter-derived flags delayed one cycle, aligned with returning fb_data.
    logic              rd_q, de_q, hs_q, vs_q, fs_q;
    logic [WORD_W-1:0] shreg_q, shreg_d;
    logic              pix_d;

    always_comb begin
        shreg_d = {1'b0, shreg_q[WORD_W-1:1]};
        pix_d   = shreg_q[0];
        if (rd_q) begin
            shreg_d = {1'b0, fb_data[WORD_W-1:1]};
            pix_d   = fb_data[0];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_q        <= 1'b0;
            de_q        <= 1'b0;
            hs_q        <= 1'b1;
            vs_q        <= 1'b1;
            fs_q        <= 1'b0;
            shreg_q     <= '0;
            video_color <= 1'b0;
            video_de    <= 1'b0;
            video_hsync <= 1'b1;
            video_vsync <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            rd_q        <= fetch;
            de_q        <= active;
            hs_q        <= hsync_raw;
            vs_q        <= vsync_raw;
            fs_q        <= first_pixel;
            shreg_q     <= shreg_d;
            video_color <= de_q & pix_d;
            video_de    <= de_q;
            video_hsync <= hs_q;
            video_vsync <= vs_q;
            frame_start <= fs_q;
        end
    end

endmodule
